// File: rtl/quadrature_modulation_generator_pkg.sv
// Shared constants for the quadrature modulation generator.
//   DATA_W   : output sample width (signed)
//   MAG_W    : quarter-wave LUT magnitude width (unsigned)
//   AMP_W    : amplitude control width
//   AMP_FULL : amplitude value meaning full scale; larger values are clamped
//   quad_e   : quadrant encoding taken from the top two phase bits
//   lut_entry: LUT content, round(MAG_MAX * sin(pi/2 * k / 2^aw))
package mod_gen_pkg;

    localparam int DATA_W   = 14;
    localparam int MAG_W    = 13;
    localparam int AMP_W    = 14;
    localparam int AMP_FULL = 8192;
    localparam int MAG_MAX  = 8191;

    typedef enum logic [1:0] {
        Q_0 = 2'd0,   // rising, positive
        Q_1 = 2'd1,   // falling, positive (mirrored index)
        Q_2 = 2'd2,   // falling, negative
        Q_3 = 2'd3    // rising, negative (mirrored index)
    } quad_e;

    // Taylor series keeps this a plain constant function (no math library);
    // terms to x^23 are far below the rounding step on [0, pi/2].
    function automatic logic [MAG_W-1:0] lut_entry(input int k, input int aw);
        real x, x2, term, sum;
        x    = 1.5707963267948966 * real'(k) / real'(1 << aw);
        x2   = x * x;
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x2 / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return MAG_W'($rtoi(real'(MAG_MAX) * sum + 0.5));
    endfunction

endpackage

// File: rtl/quadrature_modulation_generator_if.sv
// Control/sample bundle of the quadrature modulation generator.
//   en_i, freq_i, phase_off_i, amp_i : controls from the register bank
//   in_phase_o, out_phase_o, sync_o  : sine/cosine references and period strobe
// master: register bank / consumer side; slave: the generator.
interface quadrature_modulation_generator_if #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 14,
    parameter int AMP_W   = 14
);
    logic               en_i;
    logic [PHASE_W-1:0] freq_i;
    logic [PHASE_W-1:0] phase_off_i;
    logic [AMP_W-1:0]   amp_i;
    logic [DATA_W-1:0]  in_phase_o;
    logic [DATA_W-1:0]  out_phase_o;
    logic               sync_o;

    modport master (
        output en_i, freq_i, phase_off_i, amp_i,
        input  in_phase_o, out_phase_o, sync_o
    );

    modport slave (
        input  en_i, freq_i, phase_off_i, amp_i,
        output in_phase_o, out_phase_o, sync_o
    );
endinterface

// File: rtl/quadrature_modulation_generator_lut.sv
// Quarter-wave sine ROM, 2^LUT_AW+1 entries, two read ports (sin/cos).
//   clk, rst           : clock, async active-high reset (clears read registers)
//   addr_sin, addr_cos : indices 0..2^LUT_AW
//   mag_sin, mag_cos   : registered magnitudes, one cycle after the address
module sine_quarter_lut
    import mod_gen_pkg::*;
#(
    parameter int LUT_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW:0]   addr_sin,
    input  logic [LUT_AW:0]   addr_cos,
    output logic [MAG_W-1:0]  mag_sin,
    output logic [MAG_W-1:0]  mag_cos
);
    localparam int LUT_N = 1 << LUT_AW;

    logic [MAG_W-1:0] rom [0:LUT_N];

    for (genvar k = 0; k <= LUT_N; k++) begin : g_rom
        assign rom[k] = lut_entry(k, LUT_AW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_sin <= '0;
            mag_cos <= '0;
        end else begin
            mag_sin <= rom[addr_sin];
            mag_cos <= rom[addr_cos];
        end
    end
endmodule

// File: rtl/quadrature_modulation_generator.sv
// DDS quadrature reference generator for the lock-in demodulator.
//   dac_clk_i : 125 MHz DAC clock
//   dac_rst_i : async active-high reset
//   bus       : controls (en_i, freq_i, phase_off_i, amp_i) in,
//               in_phase_o (sine), out_phase_o (cosine), sync_o out
// Pipeline: acc -> S1 phase add + quadrant decode -> S2 LUT -> S3 scale/sign.
// An acc value held in cycle c shows on the outputs in cycle c+3.
module quadrature_modulation_generator
    import mod_gen_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int DATA_W  = 14
) (
    input  logic dac_clk_i,
    input  logic dac_rst_i,
    quadrature_modulation_generator_if.slave bus
);
    localparam int PH_W = LUT_AW + 2;   // quadrant + LUT address bits kept

    // ---------------- accumulator ----------------
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   acc_sum;
    logic               carry_q;     // acc currently holds a wrapped value
    logic               en_q;        // en_i one cycle ago
    logic               sync0;

    assign acc_sum = {1'b0, acc} + {1'b0, bus.freq_i};

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            acc     <= '0;
            carry_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            en_q <= bus.en_i;
            if (bus.en_i) begin
                acc     <= acc_sum[PHASE_W-1:0];
                carry_q <= acc_sum[PHASE_W];
            end else begin
                acc     <= '0;
                carry_q <= 1'b0;
            end
        end
    end

    // Period start: wrapped acc, or the acc=0 sample right after enable.
    // Both conditions OR into a single strobe.
    assign sync0 = bus.en_i & (carry_q | ~en_q);

    // ---------------- S1: phase add + decode ----------------
    // Only the top PH_W phase bits matter; the +90 degree offset lands
    // entirely inside them.
    logic [PH_W-1:0] ph_sin, ph_cos;

    assign ph_sin = PH_W'((acc + bus.phase_off_i) >> (PHASE_W - PH_W));
    assign ph_cos = ph_sin + PH_W'(1 << LUT_AW);

    function automatic logic [LUT_AW:0] quad_index(input logic [PH_W-1:0] ph);
        quad_e q;
        q = quad_e'(ph[PH_W-1 -: 2]);
        if (q == Q_1 || q == Q_3)
            return (LUT_AW+1)'(1 << LUT_AW) - {1'b0, ph[LUT_AW-1:0]};
        return {1'b0, ph[LUT_AW-1:0]};
    endfunction

    function automatic logic quad_neg(input logic [PH_W-1:0] ph);
        quad_e q;
        q = quad_e'(ph[PH_W-1 -: 2]);
        return (q == Q_2 || q == Q_3);
    endfunction

    logic [LUT_AW:0] idx_sin, idx_cos;
    logic [1:0]      neg_s1, neg_s2;     // {cos, sin}
    logic [1:0]      vld_pipe;           // enable tag for S1, S2
    logic [2:0]      sync_pipe;          // strobe aligned with S1, S2, S3

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            idx_sin   <= '0;
            idx_cos   <= '0;
            neg_s1    <= '0;
            neg_s2    <= '0;
            vld_pipe  <= '0;
            sync_pipe <= '0;
        end else begin
            idx_sin   <= quad_index(ph_sin);
            idx_cos   <= quad_index(ph_cos);
            neg_s1    <= {quad_neg(ph_cos), quad_neg(ph_sin)};
            neg_s2    <= neg_s1;
            vld_pipe  <= {vld_pipe[0], bus.en_i};
            sync_pipe <= {sync_pipe[1:0], sync0};
        end
    end

    // ---------------- S2: LUT ----------------
    logic [MAG_W-1:0] mag_sin, mag_cos;

    sine_quarter_lut #(.LUT_AW(LUT_AW)) u_lut (
        .clk      (dac_clk_i),
        .rst      (dac_rst_i),
        .addr_sin (idx_sin),
        .addr_cos (idx_cos),
        .mag_sin  (mag_sin),
        .mag_cos  (mag_cos)
    );

    // ---------------- S3: scale + sign ----------------
    logic [AMP_W-1:0]  amp_c;
    logic [DATA_W-1:0] in_phase_r, out_phase_r;

    assign amp_c = (bus.amp_i > AMP_W'(AMP_FULL)) ? AMP_W'(AMP_FULL) : bus.amp_i;

    // mag <= 8191 and amp_c <= 8192, so the result never exceeds 8191.
    function automatic logic [DATA_W-1:0] scale(input logic [MAG_W-1:0] m,
                                                input logic [AMP_W-1:0] a);
        logic [MAG_W+AMP_W-1:0] p;
        p = (MAG_W+AMP_W)'(m) * (MAG_W+AMP_W)'(a);
        return DATA_W'(p >> MAG_W);
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic neg,
                                                     input logic [DATA_W-1:0] s);
        return neg ? -s : s;
    endfunction

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            in_phase_r  <= '0;
            out_phase_r <= '0;
        end else if (vld_pipe[1]) begin
            in_phase_r  <= apply_sign(neg_s2[0], scale(mag_sin, amp_c));
            out_phase_r <= apply_sign(neg_s2[1], scale(mag_cos, amp_c));
        end else begin
            in_phase_r  <= '0;
            out_phase_r <= '0;
        end
    end

    assign bus.in_phase_o  = in_phase_r;
    assign bus.out_phase_o = out_phase_r;
    assign bus.sync_o      = sync_pipe[2];
endmodule

// File: tb/tb_quadrature_modulation_generator.sv
module tb_quadrature_modulation_generator;
    localparam logic [31:0] A  = 32'h4000_0000;
    localparam int          F  = 8191;
    localparam int          H  = 4095;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    quadrature_modulation_generator_if #(.PHASE_W(32), .DATA_W(14), .AMP_W(14)) bus ();

    quadrature_modulation_generator #(.PHASE_W(32), .LUT_AW(10), .DATA_W(14)) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .bus       (bus.slave)
    );

    typedef struct {
        logic        en;
        logic [31:0] off;
        int          amp;
        int          exp_i;
        int          exp_q;
        int          exp_s;
    } vec_t;

    vec_t vt [40];
    int   lut [1025];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ip();
        return int'($signed(bus.in_phase_o));
    endfunction
    function automatic int qp();
        return int'($signed(bus.out_phase_o));
    endfunction

    task automatic row(input int r, input logic en, input logic [31:0] off, input int amp,
                       input int ei, input int eq, input int es);
        vt[r].en = en; vt[r].off = off; vt[r].amp = amp;
        vt[r].exp_i = ei; vt[r].exp_q = eq; vt[r].exp_s = es;
    endtask

    function automatic int mdl(input logic [31:0] p, input int amp);
        int a, idx, s, ac;
        a   = int'(p[29:20]);
        idx = p[30] ? 1024 - a : a;
        ac  = (amp > 8192) ? 8192 : amp;
        s   = (lut[idx] * ac) >>> 13;
        return p[31] ? -s : s;
    endfunction

    task automatic drive(input logic en, input logic [31:0] fr, input logic [31:0] off, input int amp);
        bus.en_i = en; bus.freq_i = fr; bus.phase_off_i = off; bus.amp_i = 14'(amp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.en_i = 1'b0;
        end
    endtask

    initial begin
        int          cnt, peak, ei, eq;
        logic [31:0] acc_m, off_m;
        logic        carry_m;
        longint      sum;
        int          hi [4], hq [4], hs [4];

        for (int k = 0; k <= 1024; k++)
            lut[k] = $rtoi(8191.0 * $sin(3.14159265358979323846 / 2.0 * real'(k) / 1024.0) + 0.5);

        // 4-cycle pattern: amp 8192 -> 4096 -> 16383, offset +90 deg, 5-cycle disable
        row( 0,1,0,8192, 0, 0,0); row( 1,1,0,8192, 0, 0,0); row( 2,1,0,8192, 0, 0,0);
        row( 3,1,0,8192, 0, F,1); row( 4,1,0,8192, F, 0,0); row( 5,1,0,8192, 0,-F,0);
        row( 6,1,0,8192,-F, 0,0); row( 7,1,0,8192, 0, F,1); row( 8,1,0,8192, F, 0,0);
        row( 9,1,0,8192, 0,-F,0); row(10,1,0,8192,-F, 0,0); row(11,1,0,4096, 0, F,1);
        row(12,1,0,4096, H, 0,0); row(13,1,0,4096, 0,-H,0); row(14,1,0,4096,-H, 0,0);
        row(15,1,0,16383,0, H,1); row(16,1,0,16383,F, 0,0); row(17,1,0,16383,0,-F,0);
        row(18,1,0,16383,-F,0,0); row(19,1,A,16383,0, F,1); row(20,1,A,16383,F, 0,0);
        row(21,1,A,16383,0,-F,0); row(22,1,A,16383,0, F,0); row(23,1,A,16383,F, 0,1);
        row(24,1,A,16383,0,-F,0); row(25,1,A,16383,-F,0,0); row(26,1,A,16383,0, F,0);
        row(27,0,A,16383,F, 0,1); row(28,0,A,16383,0,-F,0); row(29,0,A,16383,-F,0,0);
        row(30,0,A,16383,0, 0,0); row(31,0,A,16383,0, 0,0); row(32,1,A,16383,0, 0,0);
        row(33,1,A,16383,0, 0,0); row(34,1,A,16383,0, 0,0); row(35,1,A,16383,F, 0,1);
        row(36,1,A,16383,0,-F,0); row(37,1,A,16383,-F,0,0); row(38,1,A,16383,0, F,0);
        row(39,1,A,16383,F, 0,1);

        // reset state
        drive(1'b0, A, 32'h0, 8192);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_phase", ip(), 0);
        check("reset_out_phase", qp(), 0);
        check("reset_sync", int'(bus.sync_o), 0);
        idle(4);

        // table
        for (int r = 0; r < 40; r++) begin
            @(posedge clk); #1;
            drive(vt[r].en, A, vt[r].off, vt[r].amp);
            @(negedge clk);
            check($sformatf("vec%0d_in", r),   ip(), vt[r].exp_i);
            check($sformatf("vec%0d_out", r),  qp(), vt[r].exp_q);
            check($sformatf("vec%0d_sync", r), int'(bus.sync_o), vt[r].exp_s);
        end

        // asynchronous reset mid-run (current sample is 0, -8191)
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_in", ip(), 0);
        check("midrst_out", qp(), 0);
        check("midrst_sync", int'(bus.sync_o), 0);
        drive(1'b1, A, 32'h0, 8192);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rel%0d_out", c), qp(), 0);
            check($sformatf("rel%0d_sync", c), int'(bus.sync_o), 0);
        end
        @(negedge clk);
        check("rel3_in", ip(), 0);
        check("rel3_out", qp(), F);
        check("rel3_sync", int'(bus.sync_o), 1);

        // freq = 0: exactly one enable strobe, constant output
        idle(4);
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            drive(1'b1, 32'h0, 32'h0, 8192);
            @(negedge clk);
            cnt += int'(bus.sync_o);
        end
        check("f0_sync_count", cnt, 1);
        check("f0_in", ip(), 0);
        check("f0_out", qp(), F);

        // freq = 2^31: sync every 2 cycles (samples 0,2,..,16 visible)
        idle(4);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            drive(1'b1, 32'h8000_0000, 32'h0, 8192);
            @(negedge clk);
            cnt += int'(bus.sync_o);
        end
        check("fhalf_sync_count", cnt, 9);

        // ~1 MHz long run against a bit-exact model
        idle(4);
        off_m   = 32'h1234_5678;
        acc_m   = 32'h0;
        carry_m = 1'b0;
        cnt     = 0;
        peak    = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            drive(1'b1, 32'd34359738, off_m, 8192);
            @(negedge clk);
            if (c >= 3) begin
                ei = hi[(c-3)%4]; eq = hq[(c-3)%4];
                check("long_in", ip(), ei);
                check("long_out", qp(), eq);
                check("long_sync", int'(bus.sync_o), hs[(c-3)%4]);
            end else begin
                check("long_in_drain", ip(), 0);
                check("long_sync_drain", int'(bus.sync_o), 0);
            end
            cnt += int'(bus.sync_o);
            if (ip() > peak)  peak = ip();
            if (-ip() > peak) peak = -ip();
            hi[c%4] = mdl(acc_m + off_m, 8192);
            hq[c%4] = mdl(acc_m + off_m + A, 8192);
            hs[c%4] = (c == 0 || carry_m) ? 1 : 0;
            sum     = longint'(acc_m) + longint'(32'd34359738);
            carry_m = sum[32];
            acc_m   = sum[31:0];
        end
        check("long_sync_in_79_81", int'(cnt >= 79 && cnt <= 81), 1);
        check("long_peak", peak, F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
